// File: rtl/ks_subtractor_pipe.sv
// rtl/ks_subtractor_pipe.sv - 3-stage Kogge-Stone a - b - bin with valid/ready flow control
// Optional build macro: KS_SUB_SAT_EN (clamp diff to zero on borrow).
module ks_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3      = ~v3 | out_ready;
  assign adv2      = ~v2 | adv3;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // Stage 0/1 combinational: per-bit P/G with carry-in folded into bit 0, then prefix levels 1 and 2.
  logic [WIDTH-1:0] nb, p0, g_l12, p_l12;
  logic             cin;

  always_comb begin
    nb    = ~b;
    cin   = ~bin;
    p0    = a ^ nb;
    g_l12 = a & nb;
    g_l12[0] = g_l12[0] | (p0[0] & cin);
    p_l12 = p0;
    // Descending index lets each level update in place without clobbering lower inputs.
    for (int i = WIDTH - 1; i >= 1; i--) begin
      g_l12[i] = g_l12[i] | (p_l12[i] & g_l12[i-1]);
      p_l12[i] = p_l12[i] & p_l12[i-1];
    end
    for (int i = WIDTH - 1; i >= 2; i--) begin
      g_l12[i] = g_l12[i] | (p_l12[i] & g_l12[i-2]);
      p_l12[i] = p_l12[i] & p_l12[i-2];
    end
  end

  logic [WIDTH-1:0] s1_p, s1_g, s1_pp;
  logic             s1_cin, s1_a15, s1_b15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_pp  <= '0;
      s1_cin <= 1'b0;
      s1_a15 <= 1'b0;
      s1_b15 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_p   <= p0;
        s1_g   <= g_l12;
        s1_pp  <= p_l12;
        s1_cin <= cin;
        s1_a15 <= a[WIDTH-1];
        s1_b15 <= b[WIDTH-1];
      end
    end
  end

  // Prefix levels 3 and 4 (spans 4 and 8) complete the group generates.
  logic [WIDTH-1:0] g_l34, p_l34;

  always_comb begin
    g_l34 = s1_g;
    p_l34 = s1_pp;
    for (int i = WIDTH - 1; i >= 4; i--) begin
      g_l34[i] = g_l34[i] | (p_l34[i] & g_l34[i-4]);
      p_l34[i] = p_l34[i] & p_l34[i-4];
    end
    for (int i = WIDTH - 1; i >= 8; i--) begin
      g_l34[i] = g_l34[i] | (p_l34[i] & g_l34[i-8]);
      p_l34[i] = p_l34[i] & p_l34[i-8];
    end
  end

  logic [WIDTH-1:0] s2_p, s2_g;
  logic             s2_cin, s2_a15, s2_b15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_p   <= '0;
      s2_g   <= '0;
      s2_cin <= 1'b0;
      s2_a15 <= 1'b0;
      s2_b15 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_p   <= s1_p;
        s2_g   <= g_l34;
        s2_cin <= s1_cin;
        s2_a15 <= s1_a15;
        s2_b15 <= s1_b15;
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0; bit 0 takes the raw carry-in.
  logic [WIDTH-1:0] raw_diff, fin_diff;
  logic             fin_bout, fin_ovf;

  always_comb begin
    raw_diff = s2_p ^ {s2_g[WIDTH-2:0], s2_cin};
    fin_bout = ~s2_g[WIDTH-1];
    fin_ovf  = (s2_a15 != s2_b15) & (raw_diff[WIDTH-1] != s2_a15);
`ifdef KS_SUB_SAT_EN
    fin_diff = fin_bout ? '0 : raw_diff;
`else
    fin_diff = raw_diff;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        diff <= fin_diff;
        bout <= fin_bout;
        ovf  <= fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// tb/tb_ks_subtractor_pipe.sv - directed and streaming checks for ks_subtractor_pipe
module tb_ks_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_cons   = 0;
  logic [17:0] exp_q[$];

  ks_subtractor_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

`ifdef KS_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Reference: plain 17-bit arithmetic, returns {diff, bout, ovf}.
  function automatic logic [17:0] ref_res(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
    logic [16:0] t;
    logic [15:0] d;
    logic        o;
    t = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
    d = t[15:0];
    o = (ra[15] != rb[15]) && (d[15] != ra[15]);
    if (SAT && t[16]) d = 16'h0000;
    return {d, t[16], o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample both handshakes just before the edge, score them, then advance one cycle.
  task automatic hs();
    logic [17:0] e;
    #1;
    if (out_valid && out_ready) begin
      n_cons++;
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("stream_out", {14'b0, diff, bout, ovf}, {14'b0, e});
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      exp_q.push_back(ref_res(a, b, bin));
    end
    tick();
  endtask

  task automatic directed(input string tag, input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb, input logic eo);
    a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_not_early"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"}, {14'b0, diff, bout, ovf}, {14'b0, ed, eb, eo});
    tick();
  endtask

  logic [15:0] bp_a[5], bp_b[5], bp_d[5];
  logic        bp_c[5], bp_bo[5], bp_o[5];
  int idx_in, idx_out, a0, c0, stall;
  logic seen;

  initial begin
    bp_a[0]=16'h0010; bp_b[0]=16'h0001; bp_c[0]=1'b0; bp_d[0]=16'h000F; bp_bo[0]=1'b0; bp_o[0]=1'b0;
    bp_a[1]=16'h0001; bp_b[1]=16'h0002; bp_c[1]=1'b0; bp_d[1]=SAT ? 16'h0000 : 16'hFFFF; bp_bo[1]=1'b1; bp_o[1]=1'b0;
    bp_a[2]=16'h7FFF; bp_b[2]=16'hFFFF; bp_c[2]=1'b0; bp_d[2]=SAT ? 16'h0000 : 16'h8000; bp_bo[2]=1'b1; bp_o[2]=1'b1;
    bp_a[3]=16'h1000; bp_b[3]=16'h0FFF; bp_c[3]=1'b1; bp_d[3]=16'h0000; bp_bo[3]=1'b0; bp_o[3]=1'b0;
    bp_a[4]=16'hFFFF; bp_b[4]=16'h0000; bp_c[4]=1'b1; bp_d[4]=16'hFFFE; bp_bo[4]=1'b0; bp_o[4]=1'b0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_outputs", {14'b0, diff, bout, ovf}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    directed("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed("under0", 16'h0000, 16'h0001, 1'b0, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    directed("under_bin", 16'h0005, 16'h0005, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    directed("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

    // Back-pressure: fill three stages with out_ready low, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = bp_a[k]; b = bp_b[k]; bin = bp_c[k]; in_valid = 1'b1;
      #1;
      chk("bp_fill_ready", {31'b0, in_ready}, 32'd1);
      tick();
    end
    a = bp_a[3]; b = bp_b[3]; bin = bp_c[3];
    #1;
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_full_valid", {31'b0, out_valid}, 32'd1);
    tick(); tick();
    chk("bp_hold_res", {14'b0, diff, bout, ovf}, {14'b0, bp_d[0], bp_bo[0], bp_o[0]});
    chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    idx_in = 3; idx_out = 0;
    for (int cyc = 0; cyc < 20 && idx_out < 5; cyc++) begin
      #1;
      if (out_valid && out_ready) begin
        chk("bp_drain_res", {14'b0, diff, bout, ovf}, {14'b0, bp_d[idx_out], bp_bo[idx_out], bp_o[idx_out]});
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      tick();
      if (idx_in < 5) begin
        a = bp_a[idx_in]; b = bp_b[idx_in]; bin = bp_c[idx_in];
      end else in_valid = 1'b0;
    end
    chk("bp_drain_count", idx_out, 32'd5);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-flight: two beats in the pipe, one already presented.
    out_ready = 1'b0;
    a = 16'h4444; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h5555; b = 16'h2222;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_diff", {16'b0, diff}, 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("mid_no_ghost", {31'b0, seen}, 32'd0);
    directed("post_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random streaming against the reference model.
    n_acc = 0; n_cons = 0;
    for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      if ($urandom_range(7) == 0) b = a;
      hs();
    end
    chk("stream_accepted", n_acc, 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && exp_q.size() > 0; cyc++) hs();
    chk("stream_drained", exp_q.size(), 32'd0);

    // Sustained throughput: 50 beats with both sides always ready.
    a0 = n_acc; c0 = n_cons; stall = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      if (!in_ready) stall++;
      hs();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) hs();
    chk("tp_stalls", stall, 32'd0);
    chk("tp_accepted", n_acc - a0, 32'd50);
    chk("tp_consumed", n_cons - c0, 32'd50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
